// File: rtl/fft_pingpong_feeder.sv
// fft_pingpong_feeder: double-buffered multi-channel sample store that streams
// one frame per accepted trigger to an FFT core over AXI-Stream.
module fft_pingpong_feeder #(
    parameter int N_SAMPLE_BITS = 32,
    parameter int NFFT = 8,
    parameter int N_CHANNELS = 1,
    localparam int AW = $clog2(NFFT),
    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                                 clk,
    input  logic                                 aresetn,
    input  logic [AW-1:0]                        wAddr,
    input  logic [CW-1:0]                        wChan,
    input  logic [N_SAMPLE_BITS-1:0]             wData,
    input  logic                                 wEn,
    input  logic                                 feedTrig,
    input  logic                                 bitRevEn,
    output logic [N_CHANNELS*N_SAMPLE_BITS-1:0]  m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic                                 feeding,
    output logic                                 trigDropped
);
    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_STREAM = 2'd2;
    logic [N_SAMPLE_BITS-1:0]            r_mem [2][N_CHANNELS][NFFT];
    logic [1:0]                          r_state;
    logic                                r_wr_sel, r_rd_sel, r_brev, r_drop;
    logic [AW-1:0]                       r_idx;
    logic [N_CHANNELS*N_SAMPLE_BITS-1:0] r_tdata;
    logic                                w_hs, w_last, w_adv;
    logic [AW-1:0]                       w_next, w_rev, w_addr;
    logic [N_CHANNELS*N_SAMPLE_BITS-1:0] w_rd;

    assign w_hs   = r_state == S_STREAM && m_axis_tready;
    assign w_last = r_idx == AW'(NFFT - 1);
    assign w_adv  = r_state == S_LOAD || (w_hs && !w_last);
    assign w_next = r_state == S_LOAD ? '0 : r_idx + AW'(1);
    assign w_addr = r_brev ? w_rev : w_next;

    always_comb begin
        for (int i = 0; i < AW; i++) w_rev[i] = w_next[AW-1-i];
    end

    for (genvar c = 0; c < N_CHANNELS; c++) begin : g_rd
        assign w_rd[c*N_SAMPLE_BITS +: N_SAMPLE_BITS] = r_mem[r_rd_sel][c][w_addr];
    end

    // The write bank swaps on the same edge as a trigger, so a coincident write lands in the outgoing bank.
    always_ff @(posedge clk) begin
        if (wEn && {1'b0, wChan} < (CW + 1)'(N_CHANNELS)) r_mem[r_wr_sel][wChan][wAddr] <= wData;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_brev   <= 1'b0;
            r_idx    <= '0;
            r_tdata  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= feedTrig && r_state != S_IDLE;
            if (w_adv) r_tdata <= w_rd;
            case (r_state)
                S_IDLE: if (feedTrig) begin
                    r_rd_sel <= r_wr_sel;
                    r_wr_sel <= ~r_wr_sel;
                    r_brev   <= bitRevEn;
                    r_idx    <= '0;
                    r_state  <= S_LOAD;
                end
                S_LOAD: r_state <= S_STREAM;
                S_STREAM: if (w_hs) begin
                    if (w_last) r_state <= S_IDLE;
                    else r_idx <= r_idx + AW'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_state == S_STREAM;
    assign m_axis_tlast  = m_axis_tvalid && w_last;
    assign feeding       = r_state != S_IDLE;
    assign trigDropped   = r_drop;
endmodule

// File: tb/tb_fft_pingpong_feeder.sv
// tb_fft_pingpong_feeder: directed checks of bank swapping, readout order,
// stalls, dropped triggers and async reset for a 3-channel, 8-point feeder.
module tb_fft_pingpong_feeder;
    localparam int W = 16, NF = 8, NC = 3, DW = NC * W;
    logic          clk = 1'b0, aresetn = 1'b0;
    logic [2:0]    wAddr = '0;
    logic [1:0]    wChan = '0;
    logic [W-1:0]  wData = '0;
    logic          wEn = 1'b0, feedTrig = 1'b0, bitRevEn = 1'b0, m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, feeding, trigDropped;
    logic [DW-1:0] e_nat [NF], e_rev [NF], e_new [NF];
    int            n_chk = 0, n_pass = 0;
    int            rv [NF] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    fft_pingpong_feeder #(.N_SAMPLE_BITS(W), .NFFT(NF), .N_CHANNELS(NC)) dut (
        .clk(clk), .aresetn(aresetn), .wAddr(wAddr), .wChan(wChan), .wData(wData),
        .wEn(wEn), .feedTrig(feedTrig), .bitRevEn(bitRevEn), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .feeding(feeding), .trigDropped(trigDropped)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wr(input logic [1:0] c, input logic [2:0] a, input logic [W-1:0] d);
        wEn = 1'b1; wChan = c; wAddr = a; wData = d;
        @(negedge clk);
        wEn = 1'b0;
    endtask

    task automatic trig(input logic br);
        feedTrig = 1'b1; bitRevEn = br;
        @(negedge clk);
        feedTrig = 1'b0;
    endtask

    task automatic fill();
        for (int k = 0; k < NF; k++) begin
            wr(2'd0, 3'(k), W'(k));
            wr(2'd1, 3'(k), W'(16'h100 + k));
            wr(2'd2, 3'(k), W'(16'h200 + k));
        end
    endtask

    // Receives one frame; in stall mode tready follows 1,0,0,1,0,0,... and every stalled beat must hold.
    task automatic rx(input string tag, input bit stall, input logic [DW-1:0] exp [NF]);
        int n = 0, cyc = 0;
        bit hold = 1'b0;
        logic [DW:0] held = '0;
        while (n < NF && cyc < 100) begin
            m_axis_tready = stall ? (cyc % 3 == 0) : 1'b1;
            if (hold) check($sformatf("%s hold%0d", tag, n), {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
            hold = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("%s beat%0d", tag, n), 64'(m_axis_tdata), 64'(exp[n]));
                check($sformatf("%s last%0d", tag, n), 64'(m_axis_tlast), 64'(n == NF - 1));
                n++;
            end else if (m_axis_tvalid) begin
                hold = 1'b1;
                held = {m_axis_tlast, m_axis_tdata};
            end
            @(negedge clk);
            cyc++;
        end
        m_axis_tready = 1'b0;
        check($sformatf("%s count", tag), 64'(n), 64'(NF));
    endtask

    task automatic frame_end(input string tag);
        check({tag, " feeding end"}, 64'(feeding), 64'(0));
        check({tag, " tvalid end"}, 64'(m_axis_tvalid), 64'(0));
        check({tag, " tlast end"}, 64'(m_axis_tlast), 64'(0));
    endtask

    initial begin
        for (int k = 0; k < NF; k++) begin
            e_nat[k] = {W'(16'h200 + k), W'(16'h100 + k), W'(k)};
            e_new[k] = {W'(16'h200 + k), W'(16'h100 + k), W'(16'h50 + k)};
        end
        for (int k = 0; k < NF; k++) e_rev[k] = e_nat[rv[k]];
        e_new[3][W-1:0] = 16'h00AA;

        repeat (2) @(negedge clk);
        check("rst tvalid", 64'(m_axis_tvalid), 64'(0));
        check("rst tlast", 64'(m_axis_tlast), 64'(0));
        check("rst tdata", 64'(m_axis_tdata), 64'(0));
        check("rst feeding", 64'(feeding), 64'(0));
        check("rst drop", 64'(trigDropped), 64'(0));
        aresetn = 1'b1;
        @(negedge clk);

        fill();
        wr(2'd3, 3'd2, 16'hDEAD);
        trig(1'b0);
        check("A feeding T+1", 64'(feeding), 64'(1));
        check("A tvalid T+1", 64'(m_axis_tvalid), 64'(0));
        @(negedge clk);
        check("A tvalid T+2", 64'(m_axis_tvalid), 64'(1));
        rx("A", 1'b0, e_nat);
        frame_end("A");

        fill();
        trig(1'b1);
        @(negedge clk);
        rx("B", 1'b0, e_rev);
        frame_end("B");

        trig(1'b0);
        @(negedge clk);
        fork
            rx("C", 1'b1, e_nat);
            begin
                for (int k = 0; k < NF; k++) wr(2'd0, 3'(k), W'(16'h50 + k));
                trig(1'b0);
                check("C drop pulse", 64'(trigDropped), 64'(1));
                check("C drop feeding", 64'(feeding), 64'(1));
                @(negedge clk);
                check("C drop clear", 64'(trigDropped), 64'(0));
            end
        join
        frame_end("C");

        feedTrig = 1'b1; bitRevEn = 1'b0;
        wEn = 1'b1; wChan = 2'd0; wAddr = 3'd3; wData = 16'h00AA;
        @(negedge clk);
        feedTrig = 1'b0; wEn = 1'b0;
        @(negedge clk);
        rx("D", 1'b0, e_new);
        frame_end("D");

        trig(1'b0);
        @(negedge clk);
        m_axis_tready = 1'b1;
        repeat (4) @(negedge clk);
        check("E beat4", 64'(m_axis_tdata), 64'(e_nat[4]));
        aresetn = 1'b0;
        #1;
        check("E rst tvalid", 64'(m_axis_tvalid), 64'(0));
        check("E rst tlast", 64'(m_axis_tlast), 64'(0));
        check("E rst feeding", 64'(feeding), 64'(0));
        check("E rst tdata", 64'(m_axis_tdata), 64'(0));
        m_axis_tready = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        trig(1'b0);
        @(negedge clk);
        rx("F", 1'b0, e_nat);
        frame_end("F");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
